// File: rtl/mdc_pkg.sv
// Shared constants and FSM state type for the MDC Hamming front end.
//   N_ELEM  : matrix elements per frame (4x4, row-major)
//   DATA_W  : decoded element width, DATA_CW its Hamming(15,11) code width
//   MODE_W  : decoded mode width, MODE_CW its Hamming(9,5) code width
package mdc_pkg;
  localparam int N_ELEM  = 16;
  localparam int DATA_W  = 11;
  localparam int DATA_CW = 15;
  localparam int MODE_W  = 5;
  localparam int MODE_CW = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;
endpackage

// File: rtl/hamming_dec.sv
// Combinational Hamming single-error-correcting decoder.
//   code [CW-1:0] : coded word; code[CW-1-i] is Hamming position i+1
//   data [DW-1:0] : corrected payload, non-power-of-two positions ascending, MSB first
//   err           : syndrome is nonzero
// A syndrome that points past CW names no real bit, so the word passes
// through uncorrected (err is still raised).
module hamming_dec #(
  parameter int CW = 15,
  parameter int DW = 11
) (
  input  logic [CW-1:0] code,
  output logic [DW-1:0] data,
  output logic          err
);
  localparam int SW = $clog2(CW + 1);

  logic [SW-1:0] syn;

  always_comb begin
    syn = '0;
    for (int p = 1; p <= CW; p++)
      if (code[CW-p]) syn = syn ^ SW'(p);
  end

  assign err = (syn != '0);

  // Correction is folded into extraction: parity positions are never
  // read, so flipping them would be wasted logic.
  always_comb begin
    int k;
    data = '0;
    k    = DW - 1;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[k] = code[CW-p] ^ (syn == SW'(p));
        k = k - 1;
      end
    end
  end
endmodule

// File: rtl/mdc_hamming_frontend.sv
// Upstream MDC stage: decodes a Hamming-coded serial element stream,
// assembles a 4x4 matrix of 11-bit elements plus a 5-bit mode, and
// hands it to the determinant core over valid/ready.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_data    : coded element stream (15-bit code)
//   in_mode             : 9-bit coded mode, taken from a frame's first word
//   mat_valid/mat_ready : handoff to the core; data held stable while valid
//   mat_data            : element k at [k*11 +: 11], k = row*4 + col
//   mat_mode            : corrected mode
//   ovf                 : sticky, a word arrived while a matrix was held
//   mat_errs            : (MDC_DEC_ERRSTAT_EN only) nonzero syndromes in the frame
module mdc_hamming_frontend
  import mdc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_CW-1:0]       in_data,
  input  logic [MODE_CW-1:0]       in_mode,
  output logic                     mat_valid,
  input  logic                     mat_ready,
  output logic [N_ELEM*DATA_W-1:0] mat_data,
  output logic [MODE_W-1:0]        mat_mode,
  output logic                     ovf
`ifdef MDC_DEC_ERRSTAT_EN
  , output logic [4:0]             mat_errs
`endif
);
  state_t              state_q, state_d;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   dec_data;
  logic [MODE_W-1:0]   dec_mode;
  logic                err_d, err_m;

  hamming_dec #(.CW(DATA_CW), .DW(DATA_W)) u_dec_data (
    .code(in_data), .data(dec_data), .err(err_d)
  );

  hamming_dec #(.CW(MODE_CW), .DW(MODE_W)) u_dec_mode (
    .code(in_mode), .data(dec_mode), .err(err_m)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COLLECT;
      COLLECT: if (in_valid && cnt == 4'd15) state_d = HOLD;
      HOLD:    if (mat_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mat_valid = (state_q == HOLD);

  // cnt wraps 15->0 as the last word lands, ready for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mat_data <= '0;
      mat_mode <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mat_data[0 +: DATA_W] <= dec_data;
          mat_mode              <= dec_mode;
          cnt                   <= 4'd1;
        end
        COLLECT: if (in_valid) begin
          mat_data[int'(cnt)*DATA_W +: DATA_W] <= dec_data;
          cnt                                  <= cnt + 4'd1;
        end
        HOLD: if (in_valid) ovf <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MDC_DEC_ERRSTAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_errs <= '0;
    end else if (in_valid) begin
      if (state_q == IDLE)         mat_errs <= 5'(err_d) + 5'(err_m);
      else if (state_q == COLLECT) mat_errs <= mat_errs + 5'(err_d);
    end
  end
`else
  logic errs_unused;
  assign errs_unused = err_d ^ err_m;
`endif
endmodule

// File: tb/tb_mdc_hamming_frontend.sv
module tb_mdc_hamming_frontend;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [14:0]  in_data = '0;
  logic [8:0]   in_mode = '0;
  logic         mat_valid;
  logic         mat_ready = 1'b0;
  logic [175:0] mat_data;
  logic [4:0]   mat_mode;
  logic         ovf;
`ifdef MDC_DEC_ERRSTAT_EN
  logic [4:0]   mat_errs;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdc_hamming_frontend dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .mat_data(mat_data), .mat_mode(mat_mode), .ovf(ovf)
`ifdef MDC_DEC_ERRSTAT_EN
    , .mat_errs(mat_errs)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder: payload into non-power positions (MSB first),
  // parity bits chosen so the XOR of set-position indices is zero.
  function automatic logic [14:0] enc(input logic [10:0] d, input int cw, input int dw);
    logic [14:0] c;
    int k, s;
    c = '0; k = dw - 1; s = 0;
    for (int p = 1; p <= cw; p++)
      if ((p & (p - 1)) != 0) begin
        c[cw-p] = d[k];
        if (d[k]) s = s ^ p;
        k--;
      end
    for (int j = 0; j < 4; j++)
      if (((s >> j) & 1) != 0 && (1 << j) <= cw) c[cw-(1<<j)] = 1'b1;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic drive(input logic v, input logic [14:0] d, input logic [8:0] m, input logic rdy);
    in_valid = v; in_data = d; in_mode = m; mat_ready = rdy;
    @(negedge clk);
  endtask

  logic [14:0] fw [16];
  logic [10:0] ew [16];
  logic [8:0]  fm;
  logic [4:0]  em;
  int          eerr;

  function automatic logic [175:0] exp_mat();
    logic [175:0] e;
    e = '0;
    for (int k = 0; k < 16; k++) e[k*11 +: 11] = ew[k];
    return e;
  endfunction

  task automatic chk_out(input string nm);
    chk({nm, ":data"}, mat_data, exp_mat());
    chk({nm, ":mode"}, 176'(mat_mode), 176'(em));
`ifdef MDC_DEC_ERRSTAT_EN
    chk({nm, ":errs"}, 176'(mat_errs), 176'(5'(eerr)));
`endif
  endtask

  task automatic run_frame(input string nm, input int gap_after, input int gap_len,
                           input int hold, input logic rdy_in, input bit poke, input bit collide);
    for (int k = 0; k < 16; k++) begin
      chk({nm, ":vld_early"}, 176'(mat_valid), 176'(0));
      drive(1'b1, fw[k], (k == 0) ? fm : 9'($urandom), rdy_in);
      if (k == gap_after)
        for (int g = 0; g < gap_len; g++) drive(1'b0, 15'($urandom), 9'($urandom), rdy_in);
    end
    chk({nm, ":vld"}, 176'(mat_valid), 176'(1));
    chk_out(nm);
    for (int h = 0; h < hold; h++) begin
      drive(1'b0, 15'($urandom), 9'($urandom), 1'b0);
      chk({nm, ":hold_vld"}, 176'(mat_valid), 176'(1));
      chk({nm, ":hold_data"}, mat_data, exp_mat());
    end
    if (poke) begin
      drive(1'b1, 15'($urandom), 9'($urandom), 1'b0);
      chk({nm, ":poke_ovf"}, 176'(ovf), 176'(1));
      chk({nm, ":poke_vld"}, 176'(mat_valid), 176'(1));
      chk_out({nm, ":poke"});
    end
    drive(collide, 15'($urandom), 9'($urandom), 1'b1);
    chk({nm, ":released"}, 176'(mat_valid), 176'(0));
    if (collide) chk({nm, ":collide_ovf"}, 176'(ovf), 176'(1));
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic base_frame();
    for (int k = 0; k < 16; k++) begin
      ew[k] = 11'(k - 8);
      fw[k] = enc(ew[k], 15, 11);
    end
    fm = 9'h0A8; em = 5'b00100; eerr = 0;
  endtask

  task automatic rand_frame();
    logic [14:0] t;
    eerr = 0;
    for (int k = 0; k < 16; k++) begin
      ew[k] = 11'($urandom);
      fw[k] = enc(ew[k], 15, 11);
      if ($urandom_range(0, 3) == 0) begin
        fw[k] = fw[k] ^ (15'(1) << $urandom_range(0, 14));
        eerr++;
      end
    end
    em = 5'($urandom);
    t  = enc(11'(em), 9, 5);
    fm = t[8:0];
    if ($urandom_range(0, 2) == 0) begin
      fm = fm ^ (9'(1) << $urandom_range(0, 8));
      eerr++;
    end
  endtask

  typedef struct {
    string       nm;
    int          bad_k;
    logic [14:0] bad_code;
    logic [10:0] bad_exp;
    logic [8:0]  mcode;
    logic [4:0]  mexp;
    int          nerr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"clean",      -1, 15'h0000, 11'd0,    9'h0A8, 5'b00100, 0};
    tbl[1] = '{"data_fix",    3, 15'h2001, 11'd5,    9'h0A8, 5'b00100, 1};
    tbl[2] = '{"mode_par",   -1, 15'h0000, 11'd0,    9'h1A8, 5'b00100, 1};
    tbl[3] = '{"mode_nofix", -1, 15'h0000, 11'd0,    9'h006, 5'b00010, 1};
    tbl[4] = '{"data_pos15", 15, 15'h0001, 11'd0,    9'h0A8, 5'b00100, 1};
    tbl[5] = '{"data_pos8",   0, enc(11'h7F8, 15, 11) ^ 15'h0080, 11'h7F8, 9'h0A8, 5'b00100, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst:vld",  176'(mat_valid), 176'(0));
    chk("rst:data", mat_data, 176'(0));
    chk("rst:mode", 176'(mat_mode), 176'(0));
    chk("rst:ovf",  176'(ovf), 176'(0));
`ifdef MDC_DEC_ERRSTAT_EN
    chk("rst:errs", 176'(mat_errs), 176'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames on top of the encode(k-8) base frame
    for (int i = 0; i < 6; i++) begin
      base_frame();
      if (tbl[i].bad_k >= 0) begin
        fw[tbl[i].bad_k] = tbl[i].bad_code;
        ew[tbl[i].bad_k] = tbl[i].bad_exp;
      end
      fm = tbl[i].mcode; em = tbl[i].mexp; eerr = tbl[i].nerr;
      run_frame(tbl[i].nm, -1, 0, 0, (i == 0), 1'b0, 1'b0);
    end

    // Gap of 3 idle cycles after word 7
    base_frame();
    run_frame("gap", 7, 3, 0, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the model
    for (int r = 0; r < 20; r++) begin
      rand_frame();
      run_frame("rand", $urandom_range(0, 14), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'($urandom), 1'b0, 1'b0);
    end
    chk("ovf_clear", 176'(ovf), 176'(0));

    // Handoff and new in_valid in the same cycle: word dropped, ovf set
    rand_frame();
    run_frame("collide", -1, 0, 0, 1'b0, 1'b0, 1'b1);
    rand_frame();
    run_frame("after_collide", -1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Backpressure 5 cycles then in_valid during HOLD
    rand_frame();
    run_frame("backpress", -1, 0, 5, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame after word 9
    rand_frame();
    for (int k = 0; k < 10; k++) drive(1'b1, fw[k], fm, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst:vld",  176'(mat_valid), 176'(0));
    chk("midrst:data", mat_data, 176'(0));
    chk("midrst:mode", 176'(mat_mode), 176'(0));
    chk("midrst:ovf",  176'(ovf), 176'(0));
    repeat (2) @(negedge clk);
    chk("midrst:data2", mat_data, 176'(0));
    rst_n = 1'b1;
    @(negedge clk);
    rand_frame();
    run_frame("post_rst", -1, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("post_rst:ovf", 176'(ovf), 176'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
